// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data-memory bus of the MEM-stage load/store unit.
// The slave modport is the unit itself; master is the surrounding pipeline and memory.
interface mem_access_unit_if;
    logic [31:0] ALU_RESULT;
    logic [31:0] STORE_DATA;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic        DMEM_BUSYWAIT;
    logic [31:0] DMEM_RDATA;
    logic [31:0] LOAD_DATA;
    logic        STALL;
    logic        FAULT;

    modport slave (
        input  ALU_RESULT, STORE_DATA, MEM_READ, MEM_WRITE, FUNCT3,
               DMEM_BUSYWAIT, DMEM_RDATA,
        output DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE,
               LOAD_DATA, STALL, FAULT
    );

    modport master (
        output ALU_RESULT, STORE_DATA, MEM_READ, MEM_WRITE, FUNCT3,
               DMEM_BUSYWAIT, DMEM_RDATA,
        input  DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE,
               LOAD_DATA, STALL, FAULT
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues word-aligned byte-enabled accesses, waits on BUSYWAIT,
// stalls the pipeline meanwhile and returns sign/zero-extended load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_access_unit_if.slave  bus
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  timeout_cnt;
    logic [7:0]  cnt_next;
    logic        timed_out;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        is_load_q;

    logic [1:0]  addr_lo;
    logic        req;
    logic        funct3_ok;
    logic        aligned;
    logic        legal_req;
    logic        illegal_req;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt;

    // Request decode: legality and store-side lane formatting.
    always_comb begin
        addr_lo   = bus.ALU_RESULT[1:0];
        req       = bus.MEM_READ | bus.MEM_WRITE;
        funct3_ok = 1'b0;
        aligned   = 1'b1;
        be_fmt    = 4'b0000;
        wdata_fmt = bus.STORE_DATA;
        case (bus.FUNCT3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ~bus.MEM_WRITE;
            default:                funct3_ok = 1'b0;
        endcase
        case (bus.FUNCT3[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << addr_lo;
                wdata_fmt = {4{bus.STORE_DATA[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_lo[0];
                be_fmt    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{bus.STORE_DATA[15:0]}};
            end
            2'b10: begin
                aligned   = (addr_lo == 2'b00);
                be_fmt    = 4'b1111;
                wdata_fmt = bus.STORE_DATA;
            end
            default: aligned = 1'b0;
        endcase
        legal_req   = req & ~(bus.MEM_READ & bus.MEM_WRITE) & funct3_ok & aligned;
        illegal_req = req & ~legal_req;
    end

    // Load-side lane select and extension, using the access captured at issue.
    always_comb begin
        case (addr_lo_q)
            2'd0:    sel_byte = bus.DMEM_RDATA[7:0];
            2'd1:    sel_byte = bus.DMEM_RDATA[15:8];
            2'd2:    sel_byte = bus.DMEM_RDATA[23:16];
            default: sel_byte = bus.DMEM_RDATA[31:24];
        endcase
        sel_half = addr_lo_q[1] ? bus.DMEM_RDATA[31:16] : bus.DMEM_RDATA[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_fmt = {24'd0, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_fmt = {16'd0, sel_half};
            default: load_fmt = bus.DMEM_RDATA;
        endcase
    end

    // Next state and the combinational pipeline hold.
    always_comb begin
        state_next = state;
        bus.STALL  = 1'b0;
        cnt_next   = timeout_cnt + 8'd1;
        timed_out  = bus.DMEM_BUSYWAIT && (cnt_next == TIMEOUT_LIMIT);
        case (state)
            IDLE: begin
                bus.STALL = legal_req & RESET;
                if (legal_req) state_next = ACCESS;
            end
            ACCESS: begin
                bus.STALL = 1'b1;
                if (!bus.DMEM_BUSYWAIT) state_next = COMPLETE;
                else if (timed_out)     state_next = IDLE;
            end
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Registered memory bus, load result, fault pulse and wait-state counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= IDLE;
            timeout_cnt      <= 8'd0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            is_load_q        <= 1'b0;
            bus.DMEM_ADDR    <= 32'd0;
            bus.DMEM_WDATA   <= 32'd0;
            bus.DMEM_BYTE_EN <= 4'b0000;
            bus.DMEM_READ    <= 1'b0;
            bus.DMEM_WRITE   <= 1'b0;
            bus.LOAD_DATA    <= 32'd0;
            bus.FAULT        <= 1'b0;
        end else begin
            state     <= state_next;
            bus.FAULT <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_req) begin
                        bus.DMEM_ADDR    <= {bus.ALU_RESULT[31:2], 2'b00};
                        bus.DMEM_WDATA   <= wdata_fmt;
                        bus.DMEM_BYTE_EN <= be_fmt;
                        bus.DMEM_READ    <= bus.MEM_READ;
                        bus.DMEM_WRITE   <= bus.MEM_WRITE;
                        timeout_cnt      <= 8'd0;
                        funct3_q         <= bus.FUNCT3;
                        addr_lo_q        <= addr_lo;
                        is_load_q        <= bus.MEM_READ;
                    end else if (illegal_req) begin
                        bus.FAULT <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!bus.DMEM_BUSYWAIT) begin
                        bus.DMEM_READ  <= 1'b0;
                        bus.DMEM_WRITE <= 1'b0;
                        if (is_load_q) bus.LOAD_DATA <= load_fmt;
                    end else begin
                        timeout_cnt <= cnt_next;
                        if (timed_out) begin
                            bus.DMEM_READ  <= 1'b0;
                            bus.DMEM_WRITE <= 1'b0;
                            bus.FAULT      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random accesses checked against
// an arithmetic model of legality, lane formatting, latency and load extension.
module tb_mem_access_unit;

    localparam int T = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [31:0] model_load = 32'd0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr);
        if (rd && wr) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (addr % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = size_of(f3);
        return 32'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        longint v;
        case (size_of(f3))
            1:       v = longint'(sd & 32'hFF) * 64'h01010101;
            2:       v = longint'(sd & 32'hFFFF) * 64'h00010001;
            default: v = longint'(sd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_loadval(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int     n = size_of(f3);
        longint v;
        if (n == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
        if (f3[2] == 1'b0 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic apply_stimulus(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdata, input int busy);
        bit legal;
        bit timeout;
        int ncyc;
        @(negedge CLK);
        bus.MEM_READ   = rd;
        bus.MEM_WRITE  = wr;
        bus.FUNCT3     = f3;
        bus.ALU_RESULT = addr;
        bus.STORE_DATA = sd;
        #1;
        legal = model_legal(rd, wr, f3, addr);
        check_output("stall_at_request", 32'(bus.STALL), 32'(legal));
        check_output("strobes_at_request", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
        if (!legal) begin
            @(negedge CLK);
            bus.MEM_READ  = 1'b0;
            bus.MEM_WRITE = 1'b0;
            #1;
            check_output("illegal_fault", 32'(bus.FAULT), 32'd1);
            check_output("illegal_stall", 32'(bus.STALL), 32'd0);
            check_output("illegal_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
            @(negedge CLK);
            #1;
            check_output("illegal_fault_pulse", 32'(bus.FAULT), 32'd0);
            return;
        end
        timeout = (busy >= T);
        ncyc    = timeout ? T : busy + 1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK);
            bus.DMEM_BUSYWAIT = (c <= busy);
            bus.DMEM_RDATA    = (c <= busy) ? $urandom : rdata;
            #1;
            check_output("access_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'({rd, wr}));
            check_output("access_stall", 32'(bus.STALL), 32'd1);
            check_output("access_fault", 32'(bus.FAULT), 32'd0);
            if (c == 1) begin
                check_output("dmem_addr", bus.DMEM_ADDR, addr & 32'hFFFFFFFC);
                check_output("byte_en", 32'(bus.DMEM_BYTE_EN), model_be(f3, addr));
                if (wr) check_output("wdata", bus.DMEM_WDATA, model_wdata(f3, sd));
            end
        end
        @(negedge CLK);
        bus.DMEM_BUSYWAIT = 1'b0;
        if (timeout) begin
            bus.MEM_READ  = 1'b0;
            bus.MEM_WRITE = 1'b0;
            #1;
            check_output("timeout_fault", 32'(bus.FAULT), 32'd1);
            check_output("timeout_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
            check_output("timeout_stall", 32'(bus.STALL), 32'd0);
            check_output("timeout_load_kept", bus.LOAD_DATA, model_load);
            @(negedge CLK);
            #1;
            check_output("timeout_fault_pulse", 32'(bus.FAULT), 32'd0);
        end else begin
            if (rd) model_load = model_loadval(f3, addr, rdata);
            #1;
            check_output("complete_stall", 32'(bus.STALL), 32'd0);
            check_output("complete_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
            check_output("complete_fault", 32'(bus.FAULT), 32'd0);
            check_output("load_data", bus.LOAD_DATA, model_load);
            @(negedge CLK);
            bus.MEM_READ  = 1'b0;
            bus.MEM_WRITE = 1'b0;
            #1;
            check_output("no_reissue_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
            check_output("no_reissue_stall", 32'(bus.STALL), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r_addr;
        int          sel;
        RESET             = 1'b0;
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.FUNCT3        = 3'b000;
        bus.ALU_RESULT    = 32'd0;
        bus.STORE_DATA    = 32'd0;
        bus.DMEM_BUSYWAIT = 1'b0;
        bus.DMEM_RDATA    = 32'd0;
        #12;
        check_output("reset_addr", bus.DMEM_ADDR, 32'd0);
        check_output("reset_wdata", bus.DMEM_WDATA, 32'd0);
        check_output("reset_byte_en", 32'(bus.DMEM_BYTE_EN), 32'd0);
        check_output("reset_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
        check_output("reset_fault", 32'(bus.FAULT), 32'd0);
        check_output("reset_load", bus.LOAD_DATA, 32'd0);
        check_output("reset_stall", 32'(bus.STALL), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        apply_stimulus(1, 0, 3'b000, 32'h00001003, 32'd0, 32'h80FF1234, 0);
        check_output("lb_value", bus.LOAD_DATA, 32'hFFFFFF80);
        apply_stimulus(1, 0, 3'b100, 32'h00001003, 32'd0, 32'h80FF1234, 0);
        check_output("lbu_value", bus.LOAD_DATA, 32'h00000080);
        apply_stimulus(0, 1, 3'b001, 32'h00002002, 32'h1234ABCD, 32'd0, 0);
        check_output("sh_load_kept", bus.LOAD_DATA, 32'h00000080);
        apply_stimulus(1, 0, 3'b010, 32'h00001001, 32'd0, 32'd0, 0);
        apply_stimulus(1, 1, 3'b010, 32'h00001000, 32'd0, 32'd0, 0);
        apply_stimulus(1, 0, 3'b010, 32'h00000010, 32'd0, 32'hDEADBEEF, 3);
        check_output("lw_wait_value", bus.LOAD_DATA, 32'hDEADBEEF);
        apply_stimulus(0, 1, 3'b010, 32'h00000020, 32'hCAFEF00D, 32'd0, 10);
        apply_stimulus(1, 0, 3'b001, 32'h00000022, 32'd0, 32'h8001_7FFF, 0);
        apply_stimulus(1, 0, 3'b101, 32'h00000022, 32'd0, 32'h8001_7FFF, 1);
        apply_stimulus(0, 1, 3'b000, 32'h00000031, 32'h000000A5, 32'd0, 2);
        apply_stimulus(0, 1, 3'b100, 32'h00000030, 32'd0, 32'd0, 0);

        // Asynchronous reset in the middle of a waited load.
        @(negedge CLK);
        bus.MEM_READ      = 1'b1;
        bus.FUNCT3        = 3'b010;
        bus.ALU_RESULT    = 32'h00000040;
        bus.DMEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check_output("midreset_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE}), 32'd0);
        check_output("midreset_stall", 32'(bus.STALL), 32'd0);
        check_output("midreset_load", bus.LOAD_DATA, 32'd0);
        model_load        = 32'd0;
        bus.MEM_READ      = 1'b0;
        bus.DMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        apply_stimulus(1, 0, 3'b010, 32'h00000044, 32'd0, 32'h13579BDF, 0);

        for (int i = 0; i < 40; i++) begin
            sel    = $urandom_range(0, 4);
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~(32'(size_of(3'($urandom_range(0, 2)))) - 32'd1);
            apply_stimulus(sel == 0 || sel == 2 || sel == 3, sel == 1 || sel == 2 || sel == 4,
                           3'($urandom_range(0, 7)), r_addr, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit of the 5-stage RV32IM pipeline. It sits directly downstream of the EX-stage ALU and takes the registered ALU result from the EX/MEM register as the effective address. It issues word-aligned requests with byte enables to the data memory and handshakes on DMEM_BUSYWAIT. It stalls the pipeline until the access completes and returns sign/zero-extended load data to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS cycles with DMEM_BUSYWAIT high before the access is aborted with FAULT (legal range 1..255)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
ALU_RESULT  input  32  effective address from EX/MEM register
STORE_DATA  input  32  rs2 value for stores
MEM_READ  input  1  load request
MEM_WRITE  input  1  store request
FUNCT3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
DMEM_ADDR  output  32  word address {ALU_RESULT[31:2],2'b00}, registered
DMEM_WDATA  output  32  lane-replicated store data, registered
DMEM_BYTE_EN  output  4  byte lane enables, registered
DMEM_READ  output  1  memory read strobe, registered
DMEM_WRITE  output  1  memory write strobe, registered
DMEM_BUSYWAIT  input  1  memory busy; access completes on the first rising edge in ACCESS where it is low
DMEM_RDATA  input  32  memory read word, valid when BUSYWAIT is low
LOAD_DATA  output  32  extended load result, registered
STALL  output  1  combinational pipeline hold
FAULT  output  1  one-cycle pulse on a misaligned, illegal, or timed-out access

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; DMEM_ADDR, DMEM_WDATA and LOAD_DATA = 0; DMEM_BYTE_EN = 0; DMEM_READ, DMEM_WRITE and FAULT = 0; timeout counter = 0. Reset mid-access drops the strobes immediately with no completion.
- FSM states IDLE, ACCESS, COMPLETE.
- IDLE, no request: STALL = 0.
- IDLE, legal request: STALL = 1. At the edge: register the DMEM outputs, raise DMEM_READ or DMEM_WRITE, clear the counter, go to ACCESS.
- IDLE, illegal request: no memory access, STALL = 0. FAULT = 1 for the next cycle; state stays IDLE. Illegal means any of:
  - MEM_READ and MEM_WRITE both set
  - FUNCT3 not in the legal set for the operation (stores accept only 000/001/010)
  - H/HU with addr[0] = 1
  - W with addr[1:0] != 0
- ACCESS: STALL = 1; strobes and outputs held stable.
  - BUSYWAIT low at the edge: drop the strobes; for loads, register formatted LOAD_DATA; go to COMPLETE.
  - BUSYWAIT high: counter increments. When the counter reaches TIMEOUT_CYCLES, drop the strobes, pulse FAULT, leave LOAD_DATA unchanged, and go to IDLE.
- COMPLETE: STALL = 0 so the pipeline advances at this edge; unconditionally go to IDLE. The request inputs are ignored here, so the held instruction is never re-issued.
- Minimum latency: request in cycle N; STALL high in N and N+1; LOAD_DATA valid and STALL low in N+2.
- Store formatting, with a = addr[1:0]:
  - SB: BYTE_EN = 1<<a; WDATA = STORE_DATA[7:0] replicated x4.
  - SH: BYTE_EN = 0011 when a = 0, 1100 when a = 2; WDATA = STORE_DATA[15:0] replicated x2.
  - SW: BYTE_EN = 1111; WDATA = STORE_DATA.
- Load byte-enable and extension, with a = addr[1:0]:
  - Loads assert DMEM_BYTE_EN as for the same-sized store.
  - B/BU: select byte a of RDATA.
  - H/HU: select halfword a[1] of RDATA.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- LOAD_DATA holds its value until the next completed load; stores do not alter it.
- FAULT never coincides with an active strobe.

Test Plan:
- LB, ALU_RESULT = 0x00001003, DMEM_RDATA = 0x80FF1234, BUSYWAIT low -> DMEM_ADDR = 0x00001000, BYTE_EN = 1000, LOAD_DATA = 0xFFFFFF80 two cycles after the request; the same access as LBU gives 0x00000080.
- SH, ALU_RESULT = 0x00002002, STORE_DATA = 0x1234ABCD -> DMEM_WRITE = 1, BYTE_EN = 1100, WDATA = 0xABCDABCD, STALL high exactly 2 cycles, LOAD_DATA unchanged.
- LW, ALU_RESULT = 0x00001001 -> no DMEM_READ, STALL = 0, FAULT pulses 1 cycle, state IDLE; repeat with MEM_READ = MEM_WRITE = 1 -> same response.
- LW at 0x00000010 with BUSYWAIT high for 3 cycles, then low with RDATA = 0xDEADBEEF -> DMEM_READ high 4 cycles, STALL high 5 cycles, LOAD_DATA = 0xDEADBEEF.
- TIMEOUT_CYCLES = 4, BUSYWAIT stuck high on SW -> strobe drops after 4 ACCESS cycles, FAULT pulses once, STALL returns low, next request accepted normally.
- RESET driven low during ACCESS, off a clock edge -> DMEM_READ/WRITE = 0 and STALL = 0 immediately, LOAD_DATA = 0; after release, a new LW completes with normal 2-cycle latency.
